// File: rtl/elastic_stage_reg.sv
// elastic_stage_reg: pipeline stage register, valid/ready handshake, 2-entry skid buffer, flush, bubble control masking
// Ports: clk, rst_n (async active-low), flush (sync kill of held and incoming entries),
//   in_valid/in_ready/in_data/in_ctrl (upstream), out_valid/out_ready/out_data/out_ctrl (downstream),
//   occupancy (held entries 0..2).
module elastic_stage_reg #(
  parameter int DATA_W = 48,
  parameter int CTRL_W = 8,
  parameter bit CTRL_MASK = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);
  logic              m_valid, s_valid;
  logic [DATA_W-1:0] m_data, s_data;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl;
  logic              accept, pop;
  // in_ready depends on registered state only, so no combinational path from out_ready
  assign in_ready  = !s_valid;
  assign accept    = in_valid && in_ready;
  assign pop       = m_valid && out_ready;
  assign out_valid = m_valid;
  assign out_data  = m_data;
  // bubbles must never show live write/push/pop bits downstream or to forwarding
  assign out_ctrl  = (CTRL_MASK && !m_valid) ? '0 : m_ctrl;
  assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_data  <= '0;
      m_ctrl  <= '0;
      s_data  <= '0;
      s_ctrl  <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (!m_valid || pop) begin
      if (s_valid) begin
        m_data  <= s_data;
        m_ctrl  <= s_ctrl;
        m_valid <= 1'b1;
        s_valid <= 1'b0;
      end else if (accept) begin
        m_data  <= in_data;
        m_ctrl  <= in_ctrl;
        m_valid <= 1'b1;
      end else
        m_valid <= 1'b0;
    end else if (accept) begin
      s_data  <= in_data;
      s_ctrl  <= in_ctrl;
      s_valid <= 1'b1;
    end
endmodule

// File: tb/tb_elastic_stage_reg.sv
// tb_elastic_stage_reg: directed scenario tests for elastic_stage_reg (masked and unmasked builds)
module tb_elastic_stage_reg;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [47:0] in_data = '0;
  logic [7:0]  in_ctrl = '0;
  logic        in_ready, out_valid, in_ready0, out_valid0;
  logic [47:0] out_data, out_data0;
  logic [7:0]  out_ctrl, out_ctrl0;
  logic [1:0]  occupancy, occupancy0;
  int          errors = 0;
  int          checks = 0;
  always #5 clk = ~clk;
  elastic_stage_reg #(.DATA_W(48), .CTRL_W(8), .CTRL_MASK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl), .occupancy(occupancy));
  elastic_stage_reg #(.DATA_W(48), .CTRL_W(8), .CTRL_MASK(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_ctrl(out_ctrl0), .occupancy(occupancy0));
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 48'h0) begin errors++; $display("FAIL reset out_data: got %h want 0", out_data); end
    checks++; if (out_ctrl0 !== 8'h00) begin errors++; $display("FAIL reset out_ctrl(unmasked): got %h want 00", out_ctrl0); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset occupancy: got %0d want 0", occupancy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask
  task automatic test_single;
    in_valid = 1'b1; in_data = 48'h00AB_CDEF_1234; in_ctrl = 8'h04; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single out_valid: got %b want 1", out_valid); end
    checks++; if (out_data !== 48'h00AB_CDEF_1234) begin errors++; $display("FAIL single out_data: got %h want 00abcdef1234", out_data); end
    checks++; if (out_ctrl !== 8'h04) begin errors++; $display("FAIL single out_ctrl: got %h want 04", out_ctrl); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single drain out_valid: got %b want 0", out_valid); end
    checks++; if (out_ctrl !== 8'h00) begin errors++; $display("FAIL single drain out_ctrl: got %h want 00", out_ctrl); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL single drain occupancy: got %0d want 0", occupancy); end
  endtask
  task automatic test_stream;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 48'(i) * 48'h0101_0101_0101; in_ctrl = 8'(i);
      step();
      checks++; if (out_valid !== 1'b1 || out_data !== 48'(i) * 48'h0101_0101_0101)
        begin errors++; $display("FAIL stream D%0d: got v=%b %h want v=1 %h", i, out_valid, out_data, 48'(i) * 48'h0101_0101_0101); end
      checks++; if (in_ready !== 1'b1 || occupancy !== 2'd1)
        begin errors++; $display("FAIL stream D%0d rdy/occ: got %b/%0d want 1/1", i, in_ready, occupancy); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL stream drain occupancy: got %0d want 0", occupancy); end
  endtask
  task automatic test_back_pressure;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 48'hD1; in_ctrl = 8'h01;
    step();
    checks++; if (occupancy !== 2'd1 || out_data !== 48'hD1) begin errors++; $display("FAIL bp D1 at head: got occ=%0d %h want 1 d1", occupancy, out_data); end
    out_ready = 1'b0; in_data = 48'hD2; in_ctrl = 8'h02;
    step();
    checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin errors++; $display("FAIL bp full: got occ=%0d rdy=%b want 2 0", occupancy, in_ready); end
    in_data = 48'hD3; in_ctrl = 8'h03;
    step();
    checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 48'hD1)
      begin errors++; $display("FAIL bp hold D3: got occ=%0d rdy=%b %h want 2 0 d1", occupancy, in_ready, out_data); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 48'hD2 || occupancy !== 2'd1)
      begin errors++; $display("FAIL bp out D2: got v=%b %h occ=%0d want 1 d2 1", out_valid, out_data, occupancy); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 48'hD3 || occupancy !== 2'd1)
      begin errors++; $display("FAIL bp out D3: got v=%b %h occ=%0d want 1 d3 1", out_valid, out_data, occupancy); end
    step();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL bp drain: got v=%b occ=%0d want 0 0", out_valid, occupancy); end
  endtask
  task automatic test_flush;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 48'hA; in_ctrl = 8'h0A;
    step();
    in_data = 48'hB; in_ctrl = 8'h0B;
    step();
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL flush prefill occupancy: got %0d want 2", occupancy); end
    flush = 1'b1; in_data = 48'hC; in_ctrl = 8'h0C;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL flush empty: got v=%b occ=%0d want 0 0", out_valid, occupancy); end
    checks++; if (out_ctrl !== 8'h00 || in_ready !== 1'b1) begin errors++; $display("FAIL flush ctrl/rdy: got %h %b want 00 1", out_ctrl, in_ready); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush entry leaked: got v=%b %h want 0", out_valid, out_data); end
    in_valid = 1'b1; in_data = 48'hE; in_ctrl = 8'h0E;
    step();
    in_valid = 1'b0; flush = 1'b1;
    checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL flush+pop prefill: got %0d want 1", occupancy); end
    step();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL flush+pop empty: got v=%b occ=%0d want 0 0", out_valid, occupancy); end
  endtask
  task automatic test_ctrl_mask;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 48'h55; in_ctrl = 8'h24;
    step();
    in_valid = 1'b0;
    checks++; if (out_ctrl0 !== 8'h24 || out_ctrl !== 8'h24) begin errors++; $display("FAIL mask live ctrl: got %h/%h want 24/24", out_ctrl0, out_ctrl); end
    step();
    checks++; if (out_valid0 !== 1'b0 || out_ctrl0 !== 8'h24) begin errors++; $display("FAIL mask unmasked bubble: got v=%b %h want 0 24", out_valid0, out_ctrl0); end
    checks++; if (out_ctrl !== 8'h00) begin errors++; $display("FAIL mask masked bubble: got %h want 00", out_ctrl); end
  endtask
  task automatic test_async_reset;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 48'h77; in_ctrl = 8'h7F;
    step();
    in_data = 48'h88; in_ctrl = 8'h8F;
    step();
    in_valid = 1'b0;
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL async prefill occupancy: got %0d want 2", occupancy); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL async immediate: got v=%b occ=%0d rdy=%b want 0 0 1", out_valid, occupancy, in_ready); end
    checks++; if (out_data !== 48'h0 || out_ctrl0 !== 8'h00) begin errors++; $display("FAIL async regs: got %h %h want 0 00", out_data, out_ctrl0); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    test_single();
  endtask
  initial begin
    test_reset();
    test_single();
    test_stream();
    test_back_pressure();
    test_flush();
    test_ctrl_mask();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
